// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I width codes,
// FSM state encoding and the data word length.
package dmem_pkg;

    localparam int WORD_LEN = 32;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I loads and stores against one 32-bit word:
// store byte enables and merge, load extraction with sign/zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]          funct3,
    input  logic [1:0]          addrLo,
    input  logic [WORD_LEN-1:0] wdata,
    input  logic [WORD_LEN-1:0] rdword,
    output logic [3:0]          byteEn,
    output logic [WORD_LEN-1:0] wrWord,
    output logic [WORD_LEN-1:0] ldData,
    output logic                misalign
);

    logic [WORD_LEN-1:0] laneSrc;
    logic [WORD_LEN-1:0] shifted;

    always_comb begin
        byteEn   = 4'b0000;
        laneSrc  = wdata;
        misalign = 1'b0;
        case (funct3[1:0])
            2'd0: begin
                byteEn  = 4'b0001 << addrLo;
                laneSrc = {4{wdata[7:0]}};
            end
            2'd1: begin
                byteEn   = addrLo[1] ? 4'b1100 : 4'b0011;
                laneSrc  = {2{wdata[15:0]}};
                misalign = addrLo[0];
            end
            2'd2: begin
                byteEn   = 4'b1111;
                misalign = (addrLo != 2'd0);
            end
            default: begin
                byteEn = 4'b0000;
            end
        endcase
    end

    always_comb begin
        wrWord = rdword;
        for (int i = 0; i < 4; i++) begin
            if (byteEn[i]) begin
                wrWord[8*i +: 8] = laneSrc[8*i +: 8];
            end
        end
    end

    assign shifted = rdword >> {addrLo, 3'b000};

    always_comb begin
        ldData = '0;
        case (funct3)
            F3_B:    ldData = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ldData = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    ldData = rdword;
            F3_BU:   ldData = {24'd0, shifted[7:0]};
            F3_HU:   ldData = {16'd0, shifted[15:0]};
            default: ldData = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store, programmable wait
// states, word-organised array behind RV32I lane steering.
//
// state | meaning
// IDLE  | req_ready=1, waiting for a request
// WAIT  | wait counter running, request latched
// RESP  | response held until rsp_ready
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [31:0]         req_addr,
    input  logic [2:0]          req_funct3,
    input  logic [31:0]         req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WORD_LEN-1:0] rsp_rdata,
    output logic                rsp_err
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    dmem_state_e state;
    logic [3:0]  waitCnt;

    logic        reqWriteQ;
    logic [31:0] reqAddrQ;
    logic [2:0]  reqF3Q;
    logic [31:0] reqWdataQ;

    logic        accept;
    logic        execNow;
    logic        exWrite;
    logic [31:0] exAddr;
    logic [2:0]  exF3;
    logic [31:0] exWdata;

    logic [AW-1:0]       wordIdx;
    logic [WORD_LEN-1:0] rdWord;
    logic [WORD_LEN-1:0] wrWord;
    logic [WORD_LEN-1:0] ldData;
    logic [3:0]          byteEn;
    logic                misalign;
    logic                badF3;
    logic                outOfRange;
    logic                exErr;

    logic [WORD_LEN-1:0] mem [DEPTH_WORDS];

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_ready && req_valid;

    // Gated by rst so a request presented during reset cannot write the array.
    assign execNow = rst && ((accept && (WAIT_STATES == 0)) ||
                             ((state == WAIT) && (waitCnt == 4'd1)));

    // With zero wait states execution uses the live request, not the latches.
    assign exWrite = (state == IDLE) ? req_write  : reqWriteQ;
    assign exAddr  = (state == IDLE) ? req_addr   : reqAddrQ;
    assign exF3    = (state == IDLE) ? req_funct3 : reqF3Q;
    assign exWdata = (state == IDLE) ? req_wdata  : reqWdataQ;

    assign wordIdx    = exAddr[AW+1:2];
    assign outOfRange = |exAddr[31:AW+2];
    assign rdWord     = mem[wordIdx];
    assign badF3      = exWrite ? (exF3 > F3_W)
                                : ((exF3 == 3'd3) || (exF3 == 3'd6) || (exF3 == 3'd7));
    assign exErr      = misalign || badF3 || outOfRange;

    dmem_lane_align u_lane_align (
        .funct3   (exF3),
        .addrLo   (exAddr[1:0]),
        .wdata    (exWdata),
        .rdword   (rdWord),
        .byteEn   (byteEn),
        .wrWord   (wrWord),
        .ldData   (ldData),
        .misalign (misalign)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            waitCnt   <= 4'd0;
            reqWriteQ <= 1'b0;
            reqAddrQ  <= '0;
            reqF3Q    <= '0;
            reqWdataQ <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        reqWriteQ <= req_write;
                        reqAddrQ  <= req_addr;
                        reqF3Q    <= req_funct3;
                        reqWdataQ <= req_wdata;
                        waitCnt   <= WAIT_LOAD;
                        state     <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    waitCnt <= waitCnt - 4'd1;
                    if (waitCnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (execNow) begin
                rsp_err   <= exErr;
                rsp_rdata <= (exErr || exWrite) ? '0 : ldData;
            end
        end
    end

    // The array is deliberately not reset; a committed store survives reset.
    always_ff @(posedge clk) begin
        if (execNow && exWrite && !exErr && (|byteEn)) begin
            mem[wordIdx] <= wrWord;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: two responders (2 and 0 wait states) driven with
// directed and random requests against a byte-level memory model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  reqValid, reqReady, reqWrite, rspValid, rspReady, rspErr;
    logic [31:0] reqAddr  [2];
    logic [31:0] reqWdata [2];
    logic [31:0] rspRdata [2];
    logic [2:0]  reqF3    [2];

    logic [31:0] mdl [2][1024];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_write(reqWrite[0]),
        .req_addr(reqAddr[0]), .req_funct3(reqF3[0]), .req_wdata(reqWdata[0]),
        .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]),
        .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0])
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_write(reqWrite[1]),
        .req_addr(reqAddr[1]), .req_funct3(reqF3[1]), .req_wdata(reqWdata[1]),
        .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]),
        .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request through both handshakes; hold = extra cycles of rsp_ready=0.
    task automatic access(input int d, input bit w, input logic [31:0] a,
                          input logic [2:0] f3, input logic [31:0] wd, input int hold,
                          output logic [31:0] rd, output logic er);
        int n;
        @(negedge clk);
        n = 0;
        while (!reqReady[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready before request", {31'd0, reqReady[d]}, 32'd1);
        reqValid[d] = 1'b1;
        reqWrite[d] = w;
        reqAddr[d]  = a;
        reqF3[d]    = f3;
        reqWdata[d] = wd;
        rspReady[d] = 1'b0;
        @(posedge clk);
        #1;
        reqValid[d] = 1'b0;
        reqAddr[d]  = $urandom;
        reqWdata[d] = $urandom;
        reqF3[d]    = 3'($urandom);
        n = 0;
        while (!rspValid[d] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept-to-rsp_valid edges", n, (d == 0) ? 32'd2 : 32'd0);
        rd = rspRdata[d];
        er = rspErr[d];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("held rsp_valid", {31'd0, rspValid[d]}, 32'd1);
            chk("held rsp_rdata", rspRdata[d], rd);
            chk("held rsp_err", {31'd0, rspErr[d]}, {31'd0, er});
            chk("held req_ready", {31'd0, reqReady[d]}, 32'd0);
        end
        rspReady[d] = 1'b1;
        @(posedge clk);
        #1;
        rspReady[d] = 1'b0;
        chk("rsp_valid after handshake", {31'd0, rspValid[d]}, 32'd0);
        chk("req_ready after handshake", {31'd0, reqReady[d]}, 32'd1);
    endtask

    // Reference: error rules, then byte-wise store or load with extension.
    task automatic op(input int d, input bit w, input logic [31:0] a,
                      input logic [2:0] f3, input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er);
        int          size;
        int          off;
        int          widx;
        logic        eErr;
        logic [31:0] eRd;
        logic [31:0] v;
        logic [31:0] mask;
        size = 1 << (f3 % 4);
        off  = int'(a % 4);
        eErr = ((a >> 2) >= 1024) ||
               (w ? (f3 > 2) : (f3 == 3 || f3 >= 6)) ||
               ((a % size) != 0);
        eRd  = 32'd0;
        widx = int'((a >> 2) % 1024);
        if (!eErr && !w) begin
            v = mdl[d][widx] >> (8 * off);
            if (size < 4) begin
                mask = (32'd1 << (8 * size)) - 32'd1;
                v = v & mask;
                if (f3 < 4 && v[8*size-1]) v = v | ~mask;
            end
            eRd = v;
        end
        access(d, w, a, f3, wd, hold, rd, er);
        chk("rsp_err vs model", {31'd0, er}, {31'd0, eErr});
        chk("rsp_rdata vs model", rd, eRd);
        if (!eErr && w) begin
            for (int k = 0; k < size; k++) begin
                mdl[d][widx][8*(off+k) +: 8] = wd[8*k +: 8];
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] saved;
        logic [31:0] ra;
        bit          rw;

        rst      = 1'b0;
        reqValid = 2'b00;
        reqWrite = 2'b00;
        rspReady = 2'b00;
        for (int d = 0; d < 2; d++) begin
            reqAddr[d]  = 32'd0;
            reqWdata[d] = 32'd0;
            reqF3[d]    = 3'd0;
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("reset req_ready", {31'd0, reqReady[d]}, 32'd1);
            chk("reset rsp_valid", {31'd0, rspValid[d]}, 32'd0);
            chk("reset rsp_rdata", rspRdata[d], 32'd0);
            chk("reset rsp_err", {31'd0, rspErr[d]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                op(d, 1'b1, 32'(i * 4), 3'd2, $urandom, 0, rd, er);
            end
        end

        op(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 0, rd, er);
        op(0, 1'b0, 32'h10, 3'd2, 32'h0, 0, rd, er);
        chk("LW 0x10", rd, 32'hDEADBEEF);
        chk("LW 0x10 err", {31'd0, er}, 32'd0);

        op(0, 1'b1, 32'h11, 3'd0, 32'h0000007F, 0, rd, er);
        op(0, 1'b0, 32'h10, 3'd2, 32'h0, 0, rd, er);
        chk("LW after SB", rd, 32'hDEAD7FEF);
        op(0, 1'b0, 32'h13, 3'd0, 32'h0, 0, rd, er);
        chk("LB 0x13", rd, 32'hFFFFFFDE);
        op(0, 1'b0, 32'h13, 3'd4, 32'h0, 0, rd, er);
        chk("LBU 0x13", rd, 32'h000000DE);
        op(0, 1'b0, 32'h12, 3'd1, 32'h0, 0, rd, er);
        chk("LH 0x12", rd, 32'hFFFFDEAD);

        op(0, 1'b0, 32'h02, 3'd2, 32'h0, 0, rd, er);
        chk("LW 0x02 err", {31'd0, er}, 32'd1);
        chk("LW 0x02 rdata", rd, 32'd0);
        saved = mdl[0][1];
        op(0, 1'b1, 32'h05, 3'd1, 32'h1234ABCD, 0, rd, er);
        chk("SH 0x05 err", {31'd0, er}, 32'd1);
        op(0, 1'b0, 32'h04, 3'd2, 32'h0, 0, rd, er);
        chk("word 0x04 after bad SH", rd, saved);
        op(0, 1'b0, 32'h08, 3'd3, 32'h0, 0, rd, er);
        chk("load funct3=3 err", {31'd0, er}, 32'd1);

        saved = mdl[0][0];
        op(0, 1'b1, 32'h1000, 3'd2, 32'hCAFEF00D, 0, rd, er);
        chk("SW 0x1000 err", {31'd0, er}, 32'd1);
        op(0, 1'b0, 32'h0, 3'd2, 32'h0, 0, rd, er);
        chk("LW 0x0 after out-of-range SW", rd, saved);

        op(0, 1'b0, 32'h10, 3'd2, 32'h0, 5, rd, er);
        chk("backpressured LW 0x10", rd, 32'hDEAD7FEF);

        // Reset while the SW to 0x20 sits in WAIT.
        saved = mdl[0][8];
        @(negedge clk);
        reqValid[0] = 1'b1;
        reqWrite[0] = 1'b1;
        reqAddr[0]  = 32'h20;
        reqF3[0]    = 3'd2;
        reqWdata[0] = 32'h55;
        @(posedge clk);
        #1;
        reqValid[0] = 1'b0;
        chk("in WAIT req_ready", {31'd0, reqReady[0]}, 32'd0);
        rst = 1'b0;
        #1;
        chk("mid-op reset req_ready", {31'd0, reqReady[0]}, 32'd1);
        chk("mid-op reset rsp_valid", {31'd0, rspValid[0]}, 32'd0);
        chk("mid-op reset rsp_rdata", rspRdata[0], 32'd0);
        chk("mid-op reset rsp_err", {31'd0, rspErr[0]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        op(0, 1'b0, 32'h20, 3'd2, 32'h0, 0, rd, er);
        chk("LW 0x20 after dropped SW", rd, saved);

        op(1, 1'b1, 32'h24, 3'd2, 32'h89ABCDEF, 0, rd, er);
        op(1, 1'b0, 32'h26, 3'd5, 32'h0, 0, rd, er);
        chk("zero-wait LHU 0x26", rd, 32'h000089AB);

        for (int i = 0; i < 60; i++) begin
            rw = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 7) == 0) ? (32'h1000 + 32'($urandom_range(0, 255)))
                                             : 32'($urandom_range(0, 63));
            op(i % 2, rw, ra, 3'($urandom_range(0, 7)), $urandom,
               ($urandom_range(0, 3) == 0) ? 2 : 0, rd, er);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
